// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares the byte-wide external RAM port between the IF and MEM
//             pipeline stages. Multi-byte accesses run as byte-serial bursts.
//             Read bytes are assembled little-endian into a 32-bit word.
//             stall_ram holds the pipeline while a MEM access is outstanding.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   system clock, rising edge
//    rst        in   1   asynchronous reset, active low
//    rdy        in   1   global ready; low freezes all state (ram_wr forced 0)
//    if_req     in   1   IF fetch request, held until if_done
//    if_addr    in  32   IF fetch address (always a 4-byte read)
//    if_data    out 32   fetched word, valid with if_done
//    if_done    out  1   one-cycle IF completion pulse
//    mem_req    in   1   MEM request, held until mem_done
//    mem_we     in   1   1 = write, 0 = read
//    mem_addr   in  32   MEM byte address
//    mem_wdata  in  32   MEM write data, low byte first
//    mem_len    in   3   byte count 1, 2 or 4 (other values mean 4)
//    mem_rdata  out 32   MEM read data, zero-filled, valid with mem_done
//    mem_done   out  1   one-cycle MEM completion pulse
//    stall_ram  out  1   mem_req & ~mem_done
//    ram_din    in   8   RAM read data (byte addressed in previous active cycle)
//    ram_dout   out  8   RAM write data
//    ram_a      out 32   RAM address
//    ram_wr     out  1   RAM write strobe
//  Build option
//    MEM_ARB_FAIR_EN : when defined, simultaneous requests alternate between
//                      MEM and IF; otherwise MEM always wins.
// ============================================================================
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_len,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        stall_ram,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [2:0] C_LEN_WORD = 3'd4;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic [2:0]  len_q,   len_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q,  data_d;
  logic        mem_id_q, mem_id_d;   // 1 = current grant belongs to MEM

  logic        grant_mem;
  logic        grant_if;
  logic [2:0]  mem_len_norm;
  logic [1:0]  cap_idx;

  // Byte count after folding illegal encodings onto a full word.
  assign mem_len_norm = (mem_len == 3'd1) ? 3'd1 :
                        (mem_len == 3'd2) ? 3'd2 : C_LEN_WORD;

  // The byte arriving on ram_din belongs to the address issued one step earlier.
  assign cap_idx = cnt_q[1:0] - 2'd1;

`ifdef MEM_ARB_FAIR_EN
  logic last_mem_q, last_mem_d;      // 1 = MEM received the most recent grant

  // On contention the requester that did not win last time goes first.
  assign grant_mem = mem_req & (~if_req | ~last_mem_q);
`else
  assign grant_mem = mem_req;
`endif
  assign grant_if  = if_req & ~grant_mem;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    mem_id_d = mem_id_q;
`ifdef MEM_ARB_FAIR_EN
    last_mem_d = last_mem_q;
`endif
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (grant_mem) begin
            state_d  = mem_we ? MEM_WR : MEM_RD;
            addr_d   = mem_addr;
            wdata_d  = mem_wdata;
            len_d    = mem_len_norm;
            mem_id_d = 1'b1;
            cnt_d    = 3'd0;
            data_d   = 32'd0;
`ifdef MEM_ARB_FAIR_EN
            last_mem_d = 1'b1;
`endif
          end else if (grant_if) begin
            state_d  = IF_RD;
            addr_d   = if_addr;
            wdata_d  = 32'd0;
            len_d    = C_LEN_WORD;
            mem_id_d = 1'b0;
            cnt_d    = 3'd0;
            data_d   = 32'd0;
`ifdef MEM_ARB_FAIR_EN
            last_mem_d = 1'b0;
`endif
          end
        end
        IF_RD, MEM_RD: begin
          if (cnt_q != 3'd0) begin
            case (cap_idx)
              2'd0:    data_d[7:0]   = ram_din;
              2'd1:    data_d[15:8]  = ram_din;
              2'd2:    data_d[23:16] = ram_din;
              default: data_d[31:24] = ram_din;
            endcase
          end
          // cnt == len is the trailing capture-only step.
          if (cnt_q == len_q) begin
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        MEM_WR: begin
          if (cnt_q + 3'd1 == len_q) begin
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        RESP: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      len_q    <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      data_q   <= 32'd0;
      mem_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      mem_id_q <= mem_id_d;
    end
  end

`ifdef MEM_ARB_FAIR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_mem_q <= 1'b1;
    end else begin
      last_mem_q <= last_mem_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs (decoded from registered state so reset clears them at once)
  // --------------------------------------------------------------------------
  always_comb begin
    ram_a    = 32'd0;
    ram_dout = 8'd0;
    ram_wr   = 1'b0;
    case (state_q)
      IF_RD, MEM_RD: begin
        if (cnt_q != len_q) begin
          ram_a = addr_q + {29'd0, cnt_q};
        end
      end
      MEM_WR: begin
        ram_a  = addr_q + {29'd0, cnt_q};
        ram_wr = rdy;
        case (cnt_q[1:0])
          2'd0:    ram_dout = wdata_q[7:0];
          2'd1:    ram_dout = wdata_q[15:8];
          2'd2:    ram_dout = wdata_q[23:16];
          default: ram_dout = wdata_q[31:24];
        endcase
      end
      default: begin
        ram_a = 32'd0;
      end
    endcase
  end

  assign if_done   = (state_q == RESP) & ~mem_id_q;
  assign mem_done  = (state_q == RESP) &  mem_id_q;
  assign if_data   = ((state_q == RESP) & ~mem_id_q) ? data_q : 32'd0;
  assign mem_rdata = ((state_q == RESP) &  mem_id_q) ? data_q : 32'd0;
  assign stall_ram = mem_req & ~mem_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. A byte RAM model answers
//             the DUT; a reference model turns each transaction into the
//             expected per-cycle RAM port activity and completion data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [2:0]  mem_len = 3'd0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stall_ram;
  logic [7:0]  ram_din = 8'd0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .stall_ram(stall_ram),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- RAM contents: physical RAM and reference copy -----------
  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] hashb(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : hashb(a);
  endfunction

  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : hashb(a);
  endfunction

  function automatic void preload(logic [31:0] a, logic [7:0] b);
    ram_mem[a] = b;
    ref_mem[a] = b;
  endfunction

  // Synchronous byte RAM, frozen by rdy like the DUT.
  initial begin
    logic [7:0] tmp;
    forever begin
      @(posedge clk);
      tmp = ram_rd(ram_a);
      if (rdy && ram_wr) ram_mem[ram_a] = ram_dout;
      if (rdy) ram_din <= tmp;
    end
  end

  // ---------------- reference model: per-active-cycle expectations ----------
  typedef struct packed {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  dout;
    logic        ifd;
    logic        memd;
    logic [31:0] ifdat;
    logic [31:0] memdat;
  } exp_t;

  exp_t q[$];

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic int nlen(logic [2:0] l);
    return (l == 3'd1) ? 1 : (l == 3'd2) ? 2 : 4;
  endfunction

  // Grant cycle, N address cycles, one capture cycle, then the done cycle.
  function automatic void push_read(bit is_mem, logic [31:0] a, int n);
    exp_t e;
    logic [31:0] d;
    d = 32'd0;
    q.push_back(idle_e());
    for (int k = 0; k < n; k++) begin
      e = idle_e();
      e.a = a + 32'(k);
      q.push_back(e);
      d[8*k +: 8] = ref_rd(a + 32'(k));
    end
    q.push_back(idle_e());
    e = idle_e();
    if (is_mem) begin e.memd = 1'b1; e.memdat = d; end
    else        begin e.ifd  = 1'b1; e.ifdat  = d; end
    q.push_back(e);
  endfunction

  // Grant cycle, N write cycles, then the done cycle.
  function automatic void push_write(logic [31:0] a, logic [31:0] wd, int n, bit upd);
    exp_t e;
    q.push_back(idle_e());
    for (int k = 0; k < n; k++) begin
      e = idle_e();
      e.a    = a + 32'(k);
      e.wr   = 1'b1;
      e.dout = wd[8*k +: 8];
      q.push_back(e);
      if (upd) ref_mem[a + 32'(k)] = wd[8*k +: 8];
    end
    e = idle_e();
    e.memd = 1'b1;
    q.push_back(e);
  endfunction

  // ---------------- compare process -----------------------------------------
  int          mem_done_seen = 0;
  int          last_if_cyc = 0;
  int          last_mem_cyc = 0;
  int          obs_wr = 0;
  logic [31:0] obs_if_data = 32'd0;
  logic [31:0] obs_mem_rdata = 32'd0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("rst_done", {30'd0, if_done, mem_done}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_stall", 32'(stall_ram), 32'(mem_req));
        q.delete();
      end else begin
        e = (q.size() != 0) ? q[0] : idle_e();
        chk("ram_a", ram_a, e.a);
        chk("ram_wr", 32'(ram_wr), 32'(e.wr & rdy));
        chk("ram_dout", 32'(ram_dout), 32'(e.dout));
        chk("if_done", 32'(if_done), 32'(e.ifd));
        chk("mem_done", 32'(mem_done), 32'(e.memd));
        chk("if_data", if_data, e.ifdat);
        chk("mem_rdata", mem_rdata, e.memdat);
        chk("stall_ram", 32'(stall_ram), 32'(mem_req & ~e.memd));
        if (rdy && q.size() != 0) begin
          if (e.wr) obs_wr++;
          if (e.memd) begin
            mem_done_seen++;
            last_mem_cyc  = cyc;
            obs_mem_rdata = mem_rdata;
          end
          if (e.ifd) begin
            last_if_cyc = cyc;
            obs_if_data = if_data;
          end
          void'(q.pop_front());
        end
      end
    end
  end

  // ---------------- rdy driver ----------------------------------------------
  bit rand_rdy   = 1'b0;
  int stall_from = 0;
  int stall_to   = -1;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
      else          rdy = !(cyc >= stall_from && cyc <= stall_to);
    end
  end

  // ---------------- stimulus tasks ------------------------------------------
  int start;

  task automatic wait_q_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("timeout_q_empty", 32'(q.size()), 32'd0);
      q.delete();
    end
    #1;
  endtask

  task automatic do_if(logic [31:0] a, bit stall);
    @(posedge clk); #1;
    push_read(1'b0, a, 4);
    start = cyc;
    if (stall) begin stall_from = start + 2; stall_to = start + 4; end
    if_addr = a;
    if_req  = 1'b1;
    wait_q_empty();
    if_req = 1'b0;
    stall_from = 0; stall_to = -1;
  endtask

  task automatic do_mem(bit we, logic [31:0] a, logic [31:0] wd, logic [2:0] len);
    @(posedge clk); #1;
    if (we) push_write(a, wd, nlen(len), 1'b1);
    else    push_read(1'b1, a, nlen(len));
    start     = cyc;
    mem_we    = we;
    mem_addr  = a;
    mem_wdata = wd;
    mem_len   = len;
    mem_req   = 1'b1;
    wait_q_empty();
    mem_req = 1'b0;
  endtask

  task automatic do_both(logic [31:0] ia, bit we, logic [31:0] a, logic [31:0] wd,
                         logic [2:0] len);
    int s;
    int n;
    @(posedge clk); #1;
    if (we) push_write(a, wd, nlen(len), 1'b1);
    else    push_read(1'b1, a, nlen(len));
    push_read(1'b0, ia, 4);
    start     = cyc;
    s         = mem_done_seen;
    mem_we    = we;
    mem_addr  = a;
    mem_wdata = wd;
    mem_len   = len;
    mem_req   = 1'b1;
    if_addr   = ia;
    if_req    = 1'b1;
    n = 0;
    while (mem_done_seen == s && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (mem_done_seen == s) chk("timeout_mem_done", 32'(mem_done_seen), 32'(s + 1));
    #1;
    mem_req = 1'b0;
    wait_q_empty();
    if_req = 1'b0;
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    int s;
    logic [31:0] a;
    logic [31:0] a2;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    // IF fetch with known bytes
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    do_if(32'h1000, 1'b0);
    chk("if_latency", 32'(last_if_cyc - start), 32'd6);
    chk("if_word", obs_if_data, 32'h0000_0513);

    // Two-byte write
    obs_wr = 0;
    do_mem(1'b1, 32'h100, 32'hABCD_1234, 3'd2);
    chk("wr_latency", 32'(last_mem_cyc - start), 32'd3);
    chk("wr_count", 32'(obs_wr), 32'd2);
    chk("wr_byte0", 32'(ram_rd(32'h100)), 32'h34);
    chk("wr_byte1", 32'(ram_rd(32'h101)), 32'h12);
    chk("wr_untouched", 32'(ram_mem.exists(32'h102)), 32'd0);

    // Single byte read at the top of the address space, then a wrapping word
    preload(32'hFFFF_FFFF, 8'h80);
    do_mem(1'b0, 32'hFFFF_FFFF, 32'd0, 3'd1);
    chk("rd1_latency", 32'(last_mem_cyc - start), 32'd3);
    chk("rd1_data", obs_mem_rdata, 32'h0000_0080);
    preload(32'h0, 8'h11); preload(32'h1, 8'h22); preload(32'h2, 8'h33);
    do_mem(1'b0, 32'hFFFF_FFFF, 32'd0, 3'd4);
    chk("rd4_wrap_data", obs_mem_rdata, 32'h3322_1180);

    // Simultaneous requests: MEM write first, IF afterwards
    do_both(32'h0, 1'b1, 32'h200, 32'hCAFE_F00D, 3'd4);
    chk("both_mem_latency", 32'(last_mem_cyc - start), 32'd5);
    chk("both_if_latency", 32'(last_if_cyc - start), 32'd12);

    // rdy low for three cycles during a fetch
    do_if(32'h1000, 1'b1);
    chk("stall_if_latency", 32'(last_if_cyc - start), 32'd9);
    chk("stall_if_word", obs_if_data, 32'h0000_0513);

    // Reset in the middle of a word write
    @(posedge clk); #1;
    push_write(32'h9000, 32'hDEAD_BEEF, 4, 1'b0);
    s         = mem_done_seen;
    mem_we    = 1'b1;
    mem_addr  = 32'h9000;
    mem_wdata = 32'hDEAD_BEEF;
    mem_len   = 3'd4;
    mem_req   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("midrst_ram_wr", 32'(ram_wr), 32'd0);
    chk("midrst_ram_a", ram_a, 32'd0);
    chk("midrst_done", 32'(mem_done), 32'd0);
    @(posedge clk); #1;
    mem_req = 1'b0;
    #2 rst = 1'b1;
    chk("midrst_byte0", 32'(ram_rd(32'h9000)), 32'hEF);
    chk("midrst_byte1", 32'(ram_mem.exists(32'h9001)), 32'd0);
    do_if(32'h1000, 1'b0);
    chk("postrst_if_latency", 32'(last_if_cyc - start), 32'd6);
    chk("midrst_no_done", 32'(mem_done_seen), 32'(s));

    // Randomized traffic with random rdy
    rand_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                       : (32'h3000 + 32'($urandom_range(0, 31)));
      a2 = 32'h3000 + 32'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0:       do_if(a, 1'b0);
        1:       do_mem(1'b0, a, $urandom(), 3'($urandom_range(0, 7)));
        2:       do_mem(1'b1, a, $urandom(), 3'($urandom_range(0, 7)));
        default: do_both(a2, 1'($urandom_range(0, 1)), a, $urandom(),
                         3'($urandom_range(0, 7)));
      endcase
    end
    rand_rdy = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
